// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: guard/round/sticky bundle and a sticky-aware right shift.
package fpu_pkg;

    localparam int unsigned FPU_GRS_W     = 3;
    // Widest vector shr_sticky can handle; callers zero-extend into it.
    localparam int unsigned FPU_SHR_MAX_W = 64;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } grs_t;

    typedef struct packed {
        logic [FPU_SHR_MAX_W-1:0] vec;
        logic                     sticky;
    } shr_res_t;

    // Logical right shift; sticky is the OR of every bit pushed out below bit 0.
    function automatic shr_res_t shr_sticky(input logic [FPU_SHR_MAX_W-1:0] vec,
                                            input int unsigned              amt);
        shr_res_t res;
        res.vec    = (amt >= FPU_SHR_MAX_W) ? '0 : (vec >> amt);
        res.sticky = 1'b0;
        for (int unsigned i = 0; i < FPU_SHR_MAX_W; i++) begin
            if (i < amt) begin
                res.sticky = res.sticky | vec[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fpu_shr_sticky_stage.sv
// Combinational right shift of a W-bit vector with a sticky output for the bits shifted out.
module fpu_shr_sticky_stage
    import fpu_pkg::*;
#(
    parameter int unsigned W     = 34,
    parameter int unsigned AMT_W = 6
) (
    input  logic [W-1:0]     vec_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic [W-1:0]     vec_o,
    output logic             sticky_o
);

    logic [FPU_SHR_MAX_W-1:0] vec_ext;
    shr_res_t                 res;
    logic                     unused_hi;

    always_comb begin
        vec_ext        = '0;
        vec_ext[W-1:0] = vec_i;
        res            = shr_sticky(vec_ext, 32'(amt_i));
    end

    assign vec_o    = res.vec[W-1:0];
    assign sticky_o = res.sticky;
    // Upper bits are always zero since the input was zero-extended.
    assign unused_hi = ^res.vec[FPU_SHR_MAX_W-1:W];

endmodule

// File: rtl/fpu_denorm_shift.sv
// Two-stage alignment/denormalization shifter producing mantissa plus guard/round/sticky.
module fpu_denorm_shift
    import fpu_pkg::*;
#(
    parameter int unsigned LEN     = 32,
    parameter int unsigned SHAMT_W = 6,
    parameter int unsigned FINE_W  = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [LEN-1:0]     mant_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [LEN-1:0]     mant_o,
    output logic               guard_o,
    output logic               round_o,
    output logic               sticky_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int unsigned W = LEN + 2;

    logic [W-1:0]       x;
    logic [SHAMT_W-1:0] coarse_amt;
    logic [W-1:0]       coarse_vec, fine_vec;
    logic               coarse_sticky, fine_sticky;

    logic               s1_valid_q, s1_valid_d;
    logic [W-1:0]       s1_vec_q, s1_vec_d;
    logic               s1_sticky_q, s1_sticky_d;
    logic [FINE_W-1:0]  s1_fine_q, s1_fine_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic               s2_valid_q, s2_valid_d;
    logic [LEN-1:0]     s2_mant_q, s2_mant_d;
    grs_t               s2_grs_q, s2_grs_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

    logic               s1_ready, s2_ready, s1_load, s2_load;

    assign x          = {mant_i, 2'b00};
    assign coarse_amt = {shamt_i[SHAMT_W-1:FINE_W], {FINE_W{1'b0}}};

    fpu_shr_sticky_stage #(
        .W     (W),
        .AMT_W (SHAMT_W)
    ) u_coarse (
        .vec_i    (x),
        .amt_i    (coarse_amt),
        .vec_o    (coarse_vec),
        .sticky_o (coarse_sticky)
    );

    fpu_shr_sticky_stage #(
        .W     (W),
        .AMT_W (FINE_W)
    ) u_fine (
        .vec_i    (s1_vec_q),
        .amt_i    (s1_fine_q),
        .vec_o    (fine_vec),
        .sticky_o (fine_sticky)
    );

    always_comb begin
        s2_ready = ~s2_valid_q | out_ready_i;
        s1_ready = ~s1_valid_q | s2_ready;
        s1_load  = in_valid_i & s1_ready;
        s2_load  = s1_valid_q & s2_ready;

        s1_valid_d = s1_ready ? in_valid_i : s1_valid_q;
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        // Flush only kills valids; data registers may load but are never presented.
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        s1_vec_d    = s1_load ? coarse_vec : s1_vec_q;
        s1_sticky_d = s1_load ? coarse_sticky : s1_sticky_q;
        s1_fine_d   = s1_load ? shamt_i[FINE_W-1:0] : s1_fine_q;
        s1_tag_d    = s1_load ? tag_i : s1_tag_q;

        s2_mant_d = s2_mant_q;
        s2_grs_d  = s2_grs_q;
        s2_tag_d  = s2_tag_q;
        if (s2_load) begin
            s2_mant_d       = fine_vec[W-1:2];
            s2_grs_d.guard  = fine_vec[1];
            s2_grs_d.round  = fine_vec[0];
            s2_grs_d.sticky = s1_sticky_q | fine_sticky;
            s2_tag_d        = s1_tag_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= '0;
            s1_sticky_q <= 1'b0;
            s1_fine_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_mant_q   <= '0;
            s2_grs_q    <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            s1_sticky_q <= s1_sticky_d;
            s1_fine_q   <= s1_fine_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_mant_q   <= s2_mant_d;
            s2_grs_q    <= s2_grs_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign in_ready_o  = s1_ready;
    assign out_valid_o = s2_valid_q;
    assign mant_o      = s2_mant_q;
    assign guard_o     = s2_grs_q.guard;
    assign round_o     = s2_grs_q.round;
    assign sticky_o    = s2_grs_q.sticky;
    assign tag_o       = s2_tag_q;

endmodule

// File: doc/fpu_denorm_shift.md
Name: fpu_denorm_shift

Overview:
- Pipelined alignment / denormalization shifter for the FPU: the inverse of leading-one normalization.
- Takes a mantissa and a right-shift amount, and returns the shifted mantissa plus guard, round and sticky bits for the rounding stage.
- Used for exponent alignment in add/sub, float-to-int conversion and subnormal result generation.
- Two-stage valid/ready pipeline (coarse shift, then fine shift) with a pass-through sideband tag.

Parameters:
- LEN, 32, mantissa width in bits.
- SHAMT_W, 6, shift-amount width; shifts up to 2**SHAMT_W-1 are legal.
- FINE_W, 3, low shift-amount bits handled by stage 2; stage 1 handles shamt[SHAMT_W-1:FINE_W] in multiples of 2**FINE_W. Must satisfy 1 <= FINE_W < SHAMT_W.
- TAG_W, 4, sideband tag width, carried unchanged.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous pipeline clear.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- mant_i  in  LEN  mantissa to shift.
- shamt_i  in  SHAMT_W  unsigned right-shift amount.
- tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- mant_o  out  LEN  shifted mantissa.
- guard_o  out  1  first bit below the mantissa LSB.
- round_o  out  1  second bit below the mantissa LSB.
- sticky_o  out  1  OR of all bits shifted past round.
- tag_o  out  TAG_W  tag of the current result.

Behaviour:
- Arithmetic:
  - Form X = {mant_i, 2'b00} (LEN+2 bits), then Y = X >> shamt_i.
  - mant_o = Y[LEN+1:2], guard_o = Y[1], round_o = Y[0].
  - sticky_o = OR of all bits of X that fall out below bit 0.
- Shift saturation: if shamt_i >= LEN+2, then mant_o=0, guard=round=0 and sticky_o = |mant_i.
- shamt_i = 0: mant_o = mant_i, guard/round/sticky = 0.
- Stage 1 (S1):
  - Registers X shifted by shamt_i[SHAMT_W-1:FINE_W]<<FINE_W.
  - Registers sticky1 (OR of bits lost in the coarse shift), shamt_i[FINE_W-1:0] and tag.
- Stage 2 (S2):
  - Shifts the S1 vector by the fine amount.
  - sticky = sticky1 | (bits lost in the fine shift).
  - Drives the outputs directly from registers.
- Handshake:
  - Each stage has its own valid flag.
  - s2_ready = ~s2_valid | out_ready_i; s1_ready = ~s1_valid | s2_ready; in_ready_o = s1_ready.
  - A transfer occurs when valid and ready are both high in the same cycle.
  - No combinational path from in_valid_i to out_valid_o.
  - There is a combinational path out_ready_i -> in_ready_o.
- Latency: 2 cycles from input handshake to out_valid_o, with no backpressure. Throughput is 1 result per cycle.
- Stall: with out_valid_o=1 and out_ready_i=0, all output data and tag_o hold stable. S1 holds if also valid. in_ready_o=0 once both stages are full.
- Simultaneous S2 drain and S1 advance: S2 reloads in the same cycle with no bubble.
- Reset mid-operation: rst_i clears s1_valid, s2_valid and all datapath registers to 0. The cycle after reset, out_valid_o=0 and in_ready_o=1.
- flush_i: clears both valid flags in the same cycle. An input offered in the flush cycle is dropped. Data registers need not clear. rst_i has priority over flush_i.
- Reset values: out_valid_o=0, mant_o=0, guard_o=0, round_o=0, sticky_o=0, tag_o=0. in_ready_o=1 after reset.

Decomposition:
- fpu_pkg gains:
  - FPU_GRS_W = 3 constant.
  - A grs_t packed struct {guard, round, sticky}.
  - A function shr_sticky(vec, amt) returning the shifted vector and the lost-bit OR.
- One sub-module, fpu_shr_sticky_stage: a combinational right shift of a vector by an amount, with a sticky-out. Instantiated twice (coarse and fine).

Test Plan:
- LEN=32. mant=0x80000000, shamt=31 -> mant_o=0x00000001, g=r=s=0, out_valid_o 2 cycles after the handshake.
- mant=0x00000007, shamt=3 -> mant_o=0, g=1, r=1, s=1. mant=0x80000000, shamt=33 -> mant_o=0, g=0, r=1, s=0.
- mant=0x00000001, shamt=40 (saturation) -> mant_o=0, g=r=0, s=1. mant=0x12345678, shamt=0 -> mant_o=0x12345678, grs=0.
- Back-to-back stream of 8 inputs with tags 0..7 and out_ready_i=1 -> 8 results on consecutive cycles, in tag order.
- Backpressure: hold out_ready_i=0 after the first result.
  - in_ready_o falls once 2 items are held.
  - Outputs stay stable while stalled.
  - Releasing out_ready_i drains in order with no loss or duplication.
- Assert rst_i (then, separately, flush_i) with both stages full -> next cycle out_valid_o=0, in_ready_o=1. Assert flush_i with in_valid_i=1 -> that input never appears at the output.
